div_unit: RTL and testbench



---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle. Operands are
// converted to magnitudes at accept and the result is sign-corrected when
// it is registered. Divide-by-zero and signed overflow complete on the
// accept edge.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH:0]   rem_q,      rem_d;
    logic [WIDTH-1:0] div_q,      div_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             q_neg_q,    q_neg_d;
    logic             r_neg_q,    r_neg_d;
    logic             is_rem_q,   is_rem_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q,  out_tag_d;

    // Accept-side decode: magnitudes and special cases of the incoming request.
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_by_zero;
    logic             sign_ovf;

    assign is_signed   = ~in_op[0];
    assign a_neg       = is_signed & in_a[WIDTH-1];
    assign b_neg       = is_signed & in_b[WIDTH-1];
    assign a_abs       = a_neg ? -in_a : in_a;
    assign b_abs       = b_neg ? -in_b : in_b;
    assign div_by_zero = (in_b == '0);
    assign sign_ovf    = is_signed && (in_a == MIN_NEG) && (in_b == '1);

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor,
    // keep the difference and set the quotient bit when it is non-negative.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {2'b00, div_q};
    assign trial_ok = ~trial[WIDTH+1];
    assign quo_next = {quo_q[WIDTH-2:0], trial_ok};
    assign rem_next = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
    assign quo_fix  = q_neg_q ? -quo_next : quo_next;
    assign rem_fix  = r_neg_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        // NOTE: every _d takes its _q value first so no path leaves a signal
        // unassigned; without these defaults synthesis would infer latches.
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        is_rem_d   = is_rem_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;

        if (flush) begin
            // Flush beats accept, completion and out_ready alike.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        is_rem_d  = in_op[1];
                        out_tag_d = in_tag;
                        if (div_by_zero) begin
                            out_data_d = in_op[1] ? in_a : '1;
                            state_d    = S_DONE;
                        end else if (sign_ovf) begin
                            out_data_d = in_op[1] ? '0 : MIN_NEG;
                            state_d    = S_DONE;
                        end else begin
                            quo_d   = a_abs;
                            rem_d   = '0;
                            div_d   = b_abs;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                            cnt_d   = '0;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        out_data_d = is_rem_q ? rem_fix : quo_fix;
                        state_d    = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            is_rem_q   <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            is_rem_q   <= is_rem_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic vectors, special cases, latency,
// backpressure, flush and reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result, check it, consume it.
    // exp_lat counts edges after the accept edge until out_valid is seen:
    // 32 for the iterative path, 0 for a special case (valid right after accept).
    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int exp_lat);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0000_1234;
        in_op    = ~op;
        in_tag   = ~tag;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " data"}, out_data, exp);
        chk({name, " tag"}, {27'd0, out_tag}, {27'd0, tag});
        chk({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " idle after consume"}, {31'd0, in_ready}, 32'd1);
        chk({name, " valid dropped"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic seen;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_tag", {27'd0, out_tag}, 32'd0);
        reset = 1'b0;
        tick();

        // Arithmetic vectors: 100/7 = 14 r 2; -7/2 = -3 r -1; 7/-2 = -3 r 1.
        run("divu 100/7",  OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         32);
        run("remu 100/7",  OP_REMU, 32'd100,        32'd7,          5'd3,  32'd2,          32);
        run("div -7/2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFD,  32);
        run("rem -7/2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFF,  32);
        run("rem 7/-2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd12, 32'd1,          32);
        run("divu max/1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  32);
        run("div min/2",   OP_DIV,  32'h8000_0000,  32'd2,          5'd1,  32'hC000_0000,  32);

        // Special cases complete on the accept edge.
        run("div 5/0",     OP_DIV,  32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  0);
        run("remu 5/0",    OP_REMU, 32'd5,          32'd0,          5'd14, 32'd5,          0);
        run("rem -7/0",    OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd15, 32'hFFFF_FFF9,  0);
        run("div ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  0);
        run("rem ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          0);

        // Backpressure: result and tag held for 10 cycles while out_ready is low.
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("bp valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp data hold", out_data, 32'd14);
            chk("bp tag hold", {27'd0, out_tag}, 32'd9);
        end
        chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
        chk("bp still valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release valid", {31'd0, out_valid}, 32'd0);

        // Flush at cycle 12 of CALC: back to IDLE, no result ever appears.
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush calc valid", {31'd0, out_valid}, 32'd0);
        chk("flush calc in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush calc never valid", {31'd0, seen}, 32'd0);
        run("divu 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 32);

        // Flush in DONE drops the pending result.
        in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd6;
        tick();
        in_valid = 1'b0;
        chk("flush done pre valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush done valid", {31'd0, out_valid}, 32'd0);
        chk("flush done in_ready", {31'd0, in_ready}, 32'd1);

        // Flush in IDLE with a concurrent request: nothing is accepted.
        in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd8;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush idle no accept", {31'd0, out_valid}, 32'd0);
        chk("flush idle in_ready", {31'd0, in_ready}, 32'd1);

        // Reset during CALC with a concurrent request on the reset edge.
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd5;
        tick();
        for (int i = 0; i < 5; i++) tick();
        in_op = OP_DIV; in_b = 32'd0; in_tag = 5'd21;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst calc valid", {31'd0, out_valid}, 32'd0);
        chk("rst calc in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst calc data", out_data, 32'd0);
        chk("rst calc tag", {27'd0, out_tag}, 32'd0);

        // Reset during DONE clears the held result.
        in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd7;
        tick();
        in_valid = 1'b0;
        chk("rst done pre data", out_data, 32'hFFFF_FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst done valid", {31'd0, out_valid}, 32'd0);
        chk("rst done in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst done data", out_data, 32'd0);
        chk("rst done tag", {27'd0, out_tag}, 32'd0);

        run("div min/2 after reset", OP_DIV, 32'h8000_0000, 32'd2, 5'd30, 32'hC000_0000, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
